// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and out_rd; slave is the subtractor itself.
interface serial_subtractor_if #(
    parameter int p_wordlength = 4
);
    logic [p_wordlength-1:0] in_a;
    logic [p_wordlength-1:0] in_b;
    logic                    in_bi;
    logic                    in_vld;
    logic                    in_rd;
    logic [p_wordlength-1:0] out_d;
    logic                    out_bo;
    logic                    out_ovf;
    logic                    out_vld;
    logic                    out_rd;

    modport master (
        output in_a,
        output in_b,
        output in_bi,
        output in_vld,
        output out_rd,
        input  in_rd,
        input  out_d,
        input  out_bo,
        input  out_ovf,
        input  out_vld
    );

    modport slave (
        input  in_a,
        input  in_b,
        input  in_bi,
        input  in_vld,
        input  out_rd,
        output in_rd,
        output out_d,
        output out_bo,
        output out_ovf,
        output out_vld
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB first
// over p_wordlength cycles, with valid/ready on both sides.
module serial_subtractor #(
    parameter int p_wordlength = 4
) (
    input logic clk,
    input logic rst,
    serial_subtractor_if.slave bus
);
    localparam int W  = p_wordlength;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  res;
    logic [CW-1:0] cnt;
    logic          bw;
    logic          bo;
    logic          ovf;

    logic a0;
    logic b0;
    logic d;
    logic bw_n;
    logic last;

    assign a0   = a_sr[0];
    assign b0   = b_sr[0];
    assign d    = a0 ^ b0 ^ bw;
    assign bw_n = (~a0 & b0) | (~(a0 ^ b0) & bw);
    assign last = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (bus.in_vld) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_rd) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Counter saturates on the last bit so it never wraps mid-transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            res  <= '0;
            cnt  <= '0;
            bw   <= 1'b0;
            bo   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_vld) begin
                        a_sr <= bus.in_a;
                        b_sr <= bus.in_b;
                        bw   <= bus.in_bi;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= {1'b0, a_sr[W-1:1]};
                    b_sr <= {1'b0, b_sr[W-1:1]};
                    res  <= {d, res[W-1:1]};
                    bw   <= bw_n;
                    if (last) begin
                        bo  <= bw_n;
                        ovf <= bw ^ bw_n;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_rd   = (state == IDLE);
    assign bus.out_vld = (state == DONE);
    assign bus.out_d   = res;
    assign bus.out_bo  = bo;
    assign bus.out_ovf = ovf;
endmodule
